// File: rtl/meter_pkg.sv
// meter_pkg
// Shared constants and types for the parking-meter time controller:
// display mode encoding, per-button time increments, preset load values
// and the LOW/ACTIVE threshold.
package meter_pkg;

    typedef enum logic [1:0] {
        MODE_EXPIRED = 2'd0,
        MODE_LOW     = 2'd1,
        MODE_ACTIVE  = 2'd2
    } mode_t;

    // Button increments. These are 15 bits wide so that the next-time sum
    // can exceed the 14-bit ceiling before it is saturated.
    localparam logic [14:0] ADD_U = 15'd10;
    localparam logic [14:0] ADD_L = 15'd180;
    localparam logic [14:0] ADD_R = 15'd200;
    localparam logic [14:0] ADD_D = 15'd550;

    // Preset values loaded by the level switches.
    localparam logic [13:0] PRESET_A = 14'd10;
    localparam logic [13:0] PRESET_B = 14'd205;

    // The display runs in ACTIVE mode from this many seconds upward.
    localparam logic [13:0] LOW_THRESH = 14'd200;

endpackage

// File: rtl/bin2bcd14.sv
// bin2bcd14
// Combinational double-dabble converter from a 14-bit binary value to
// four BCD digits. Inputs above 9999 are outside the meter's range and
// produce no meaningful digits.
// Ports:
//   i_bin   in  14  binary value, 0..9999
//   o_bcd3  out  4  thousands digit
//   o_bcd2  out  4  hundreds digit
//   o_bcd1  out  4  tens digit
//   o_bcd0  out  4  units digit
module bin2bcd14 (
    input  logic [13:0] i_bin,
    output logic [3:0]  o_bcd3,
    output logic [3:0]  o_bcd2,
    output logic [3:0]  o_bcd1,
    output logic [3:0]  o_bcd0
);

    // Shift register: BCD digits in [29:14], binary in [13:0].
    logic [29:0] w_sr;

    // NOTE: blocking assignments are correct here because w_sr is rebuilt
    // step by step within one evaluation; it is given a full value first
    // so no latch can be inferred.
    always_comb begin
        w_sr = {16'd0, i_bin};
        for (int i = 0; i < 14; i++) begin
            // Add 3 to any digit >= 5 so that the next shift carries
            // correctly into the digit above.
            for (int d = 0; d < 4; d++) begin
                if (w_sr[14 + 4*d +: 4] >= 4'd5) begin
                    w_sr[14 + 4*d +: 4] = w_sr[14 + 4*d +: 4] + 4'd3;
                end
            end
            w_sr = w_sr << 1;
        end
    end

    assign o_bcd3 = w_sr[29:26];
    assign o_bcd2 = w_sr[25:22];
    assign o_bcd1 = w_sr[21:18];
    assign o_bcd0 = w_sr[17:14];

endmodule

// File: rtl/meter_timer_ctrl.sv
// meter_timer_ctrl
// Parking-meter time controller. It takes the debounced button pulses and
// the preset switches, keeps the remaining time in seconds, counts it down
// once per second, and drives BCD digits plus a blank strobe for the
// seven-segment display. Every output depends on registered state only.
// Ports:
//   CLK        in   1  system clock
//   RESET      in   1  synchronous, active-high reset
//   up         in   1  pulse, adds 10 s
//   left       in   1  pulse, adds 180 s
//   right      in   1  pulse, adds 200 s
//   down       in   1  pulse, adds 550 s
//   sw_set10   in   1  level, loads 10 s while high (wins over sw_set205)
//   sw_set205  in   1  level, loads 205 s while high
//   time_s     out 14  remaining seconds
//   bcd3..bcd0 out  4  thousands..units digits of time_s
//   blank      out  1  1 = display off during this flash phase
//   mode       out  2  0 EXPIRED, 1 LOW, 2 ACTIVE
// TICKS_PER_SEC must be even and at least 4.
module meter_timer_ctrl
    import meter_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int MAX_TIME      = 9999
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        up,
    input  logic        left,
    input  logic        right,
    input  logic        down,
    input  logic        sw_set10,
    input  logic        sw_set205,
    output logic [13:0] time_s,
    output logic [3:0]  bcd3,
    output logic [3:0]  bcd2,
    output logic [3:0]  bcd1,
    output logic [3:0]  bcd0,
    output logic        blank,
    output logic [1:0]  mode
);

    localparam int TW = $clog2(TICKS_PER_SEC);
    localparam logic [TW-1:0] TCNT_HALF = TW'(TICKS_PER_SEC / 2 - 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TICKS_PER_SEC - 1);
    localparam logic [14:0]   MAX_T15   = 15'(MAX_TIME);

    logic [13:0]   r_time_s;
    logic [TW-1:0] r_tcnt;
    logic [1:0]    r_ph;

    logic          w_sec_tick;
    logic          w_half_tick;
    logic [14:0]   w_add;
    logic [14:0]   w_dec;
    logic [14:0]   w_sum;
    logic [13:0]   w_time_next;
    mode_t         w_mode;

    assign w_sec_tick  = (r_tcnt == TCNT_LAST);
    assign w_half_tick = (r_tcnt == TCNT_HALF) || w_sec_tick;

    // Buttons are one-hot in normal use; if several arrive together their
    // increments simply add.
    assign w_add = (up    ? ADD_U : 15'd0) + (left ? ADD_L : 15'd0)
                 + (right ? ADD_R : 15'd0) + (down ? ADD_D : 15'd0);

    // No decrement at zero, so the subtraction below can never underflow.
    assign w_dec = {14'd0, w_sec_tick && (r_time_s != 14'd0)};
    assign w_sum = {1'b0, r_time_s} - w_dec + w_add;

    assign w_time_next = (w_sum > MAX_T15) ? MAX_T15[13:0] : w_sum[13:0];

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_time_s <= 14'd0;
            r_tcnt   <= '0;
            r_ph     <= 2'd0;
        end else if (sw_set10 || sw_set205) begin
            // A load restarts the second so a full second passes before
            // the first decrement.
            r_time_s <= sw_set10 ? PRESET_A : PRESET_B;
            r_tcnt   <= '0;
            r_ph     <= 2'd0;
        end else begin
            r_time_s <= w_time_next;
            r_tcnt   <= w_sec_tick ? '0 : r_tcnt + TW'(1);
            if (w_half_tick) begin
                r_ph <= r_ph + 2'd1;
            end
        end
    end

    always_comb begin
        if (r_time_s == 14'd0) begin
            w_mode = MODE_EXPIRED;
        end else if (r_time_s < LOW_THRESH) begin
            w_mode = MODE_LOW;
        end else begin
            w_mode = MODE_ACTIVE;
        end
    end

    // EXPIRED flashes at 1 s period, LOW at 2 s period, ACTIVE is steady.
    always_comb begin
        unique case (w_mode)
            MODE_EXPIRED: blank = r_ph[0];
            MODE_LOW:     blank = r_ph[1];
            default:      blank = 1'b0;
        endcase
    end

    assign mode   = w_mode;
    assign time_s = r_time_s;

    bin2bcd14 u_bin2bcd (
        .i_bin  (r_time_s),
        .o_bcd3 (bcd3),
        .o_bcd2 (bcd2),
        .o_bcd1 (bcd1),
        .o_bcd0 (bcd0)
    );

endmodule
